// File: rtl/popcount_pkg.sv
// Shared types and sizing helpers for the iterative population-count engine.
package popcount_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} popcount_state_t;

  // Number of 5-bit chunks needed to cover an operand of the given width.
  function automatic int chunks(input int width);
    return (width + 4) / 5;
  endfunction

  // Width of a count that can represent 0..width inclusive.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/popcount_seq_if.sv
// Operand/result handshake bundle for popcount_seq.
// The slave modport is the engine side, and the master modport is the producer/consumer side.
interface popcount_seq_if
  import popcount_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  localparam int CW = count_width(WIDTH);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_count;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_count
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_count
  );

endinterface

// File: rtl/popcount_seq_comp53.sv
// 5:3 compressor that counts the set bits of a 5-bit slice (result 0..5).
module Comp53 (
  input  logic [4:0] bits,
  output logic [2:0] count
);

  // Add up the five single-bit terms, each widened to three bits.
  always_comb begin
    count = {2'b00, bits[0]} + {2'b00, bits[1]} + {2'b00, bits[2]}
          + {2'b00, bits[3]} + {2'b00, bits[4]};
  end

endmodule

// File: rtl/popcount_seq.sv
// Iterative population counter that feeds one 5:3 compressor five operand bits per cycle.
// Optional build macro POPCOUNT_EARLY_EXIT_EN finishes as soon as the remaining shift register is zero.
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  popcount_seq_if.slave bus
);

  localparam int NCHUNK = chunks(WIDTH);
  localparam int CW     = count_width(WIDTH);
  localparam int SRW    = 5 * NCHUNK;
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  popcount_state_t state;
  popcount_state_t state_next;

  logic [SRW-1:0]  sr;
  logic [SRW-1:0]  sr_shift;
  logic [CW-1:0]   acc;
  logic [CW-1:0]   acc_sum;
  logic [CW-1:0]   count_q;
  logic [CNTW-1:0] chunk;
  logic [2:0]      comp_out;
  logic            accept;
  logic            final_add;

  Comp53 u_comp (
    .bits  (sr[4:0]),
    .count (comp_out)
  );

  // Datapath helpers: the running sum including this cycle's chunk, and the shift register after the shift.
  always_comb begin
    sr_shift = sr >> 5;
    acc_sum  = acc + CW'(comp_out);
    accept   = bus.in_valid && bus.in_ready;
  end

  // Decide whether this RUN cycle is the final add.
  always_comb begin
    final_add = (chunk == CNTW'(NCHUNK - 1));
`ifdef POPCOUNT_EARLY_EXIT_EN
    if (sr_shift == '0) begin
      final_add = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (final_add) state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state. in_ready is forced low while reset is held.
  always_comb begin
    bus.in_ready  = (state == IDLE) && !rst;
    bus.out_valid = (state == DONE);
    bus.out_count = count_q;
  end

  // Shift register, accumulator, chunk counter and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      acc     <= '0;
      chunk   <= '0;
      count_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sr    <= SRW'(bus.in_data);
            acc   <= '0;
            chunk <= '0;
          end
        end
        RUN: begin
          sr    <= sr_shift;
          acc   <= acc_sum;
          chunk <= chunk + 1'b1;
          if (final_add) begin
            count_q <= acc_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
